ctrl_fsm: RTL

- Multi-cycle fetch/decode/execute controller that sits directly upstream of the register-file/ALU datapath.
- Owns the PC, the instruction register (IR) and the latched flag register.
- Fetches 16-bit instructions over a req/ack memory port and drives the datapath's select, register-address, opcode and immediate controls.
- Sequences loads, stores, jump-and-link and conditional branches.

---
 rtl/ctrl_fsm_pkg.sv | 47 ++++
 rtl/ctrl_fsm_cond_eval.sv | 25 ++
 rtl/ctrl_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the fetch/decode/execute controller: widths, FSM states,
// opcodes, branch condition codes and flag bit positions.
package ctrl_fsm_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int ALUOP_W = 4;
  localparam int PSR_W   = 3;

  localparam int PSR_C = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STOR  = 4'b0101;
  localparam logic [3:0] OP_JAL   = 4'b0110;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_AL = 4'b1110;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
  } instr_t;

  function automatic logic [DATA_W-1:0] ext_imm4(input logic [3:0] v, input logic sext);
    return sext ? {{(DATA_W-4){v[3]}}, v} : {{(DATA_W-4){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ctrl_fsm_cond_eval.sv
// Branch condition evaluator: decides whether a BCOND is taken from the latched
// flag register and the 4-bit condition field.
module cond_eval
  import ctrl_fsm_pkg::*;
(
  input  logic [PSR_W-1:0] flags,
  input  logic [3:0]       cond,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flags[PSR_Z];
      CC_NE:   taken = ~flags[PSR_Z];
      CC_CS:   taken = flags[PSR_C];
      CC_CC:   taken = ~flags[PSR_C];
      CC_MI:   taken = flags[PSR_N];
      CC_PL:   taken = ~flags[PSR_N];
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller owning PC, IR and flags.
// Optional single-step control is compiled in with CTRL_SINGLE_STEP_EN.
//   state  | meaning
//   FETCH  | request instruction at pc; latch IR and bump pc on ack
//   DECODE | one settle cycle for the regfile read
//   EXEC   | ALU/JAL writeback strobes, flag latch, pc redirect
//   MEM    | load/store transfer at dSrc, held until ack
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000,
  parameter bit                IMM_SEXT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PSR_W-1:0]   psrIn,
  input  logic [DATA_W-1:0]  dSrc,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic               step,
  output logic               halted,
`endif
  output logic               write,
  output logic               IMM_MUX,
  output logic               SRAM_OUT,
  output logic               RA_BUF,
  output logic [REG_W-1:0]   rSrc,
  output logic [REG_W-1:0]   rDst,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  imm,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr
);

  state_t            state;
  instr_t            ir;
  logic [PSR_W-1:0]  flags;
  logic              write_r;
  logic              go;
  logic              taken;
  logic              is_alu, is_alui, is_load, is_stor, is_jal, is_bcond;
  logic              load_done;
  logic [DATA_W-1:0] disp_sext;
  logic [DATA_W-1:0] pc_exec;

`ifdef CTRL_SINGLE_STEP_EN
  assign go     = step;
  assign halted = (state == FETCH) && !mem_req;
`else
  assign go = 1'b1;
`endif

  cond_eval u_cond_eval (
    .flags (flags),
    .cond  (ir.rd),
    .taken (taken)
  );

  assign rDst  = ir.rd;
  assign rSrc  = ir.rs;
  assign aluOp = ir.ext;
  assign imm   = ext_imm4(ir.rs, IMM_SEXT);

  always_comb begin
    is_alu    = (ir.op == OP_ALUR) || (ir.op == OP_ALUI);
    is_alui   = (ir.op == OP_ALUI);
    is_load   = (ir.op == OP_LOAD);
    is_stor   = (ir.op == OP_STOR);
    is_jal    = (ir.op == OP_JAL);
    is_bcond  = (ir.op == OP_BCOND);
    disp_sext = {{(DATA_W-8){ir.ext[3]}}, ir.ext, ir.rs};
    pc_exec   = pc;
    if (is_jal)
      pc_exec = dSrc;
    else if (is_bcond && taken)
      pc_exec = pc + disp_sext;
  end

  // Load writeback can only be known in the ack cycle itself, so it is the one
  // strobe qualified by the live mem_ack; reset masks it so an ack racing a
  // reset edge is never seen as a write.
  assign load_done = (state == MEM) && is_load && mem_ack && !reset;
  assign write     = write_r | load_done;
  assign SRAM_OUT  = load_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      flags    <= '0;
      write_r  <= 1'b0;
      IMM_MUX  <= 1'b0;
      RA_BUF   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          mem_we <= 1'b0;
          if (!mem_req) begin
            mem_addr <= pc;
            mem_req  <= go;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + 16'd1;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          write_r <= is_alu || is_jal;
          IMM_MUX <= is_alui;
          RA_BUF  <= is_jal;
          state   <= EXEC;
        end
        EXEC: begin
          write_r <= 1'b0;
          IMM_MUX <= 1'b0;
          RA_BUF  <= 1'b0;
          pc      <= pc_exec;
          if (is_alu)
            flags <= psrIn;
          if (is_load || is_stor) begin
            mem_req  <= 1'b1;
            mem_we   <= is_stor;
            mem_addr <= dSrc;
            state    <= MEM;
          end else begin
            mem_req  <= go;
            mem_addr <= pc_exec;
            state    <= FETCH;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req  <= go;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
